life_grid_engine: RTL

LIFE_GRID_ENGINE -- requirements
Module: life_grid_engine

---
 rtl/life_grid_engine.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/life_grid_engine.sv
`default_nettype none
// ============================================================================
// Module   : life_grid_engine
// Brief    : Conway's Game of Life engine over a ROWS x COLS bit grid.
//            A committed grid is shown to the display port while the next
//            generation is built row by row in a shadow grid, then committed
//            in a single cycle so the display never shows a partial result.
//
// Parameters
//   COLS  : cells per row (>= 3)
//   ROWS  : rows in the grid (>= 3)
//   CNT_W : width of the committed-generation counter
//   RW    : row address width, $clog2(ROWS) (derived)
//
// Ports
//   clk        in   1      clock, rising edge
//   reset      in   1      synchronous reset, active low
//   step       in   1      request one generation (level, sampled per cycle)
//   run_enb    in   1      step is honoured only while high
//   load_enb   in   1      write load_data to row load_row (idle only)
//   load_row   in   RW     load row address (>= ROWS ignored)
//   load_data  in   COLS   row pattern, bit 0 = column 0
//   rd_row     in   RW     display read address (>= ROWS reads zero)
//   rd_data    out  COLS   committed row rd_row, registered
//   busy       out  1      high while a generation is computed / committed
//   gen_done   out  1      one-cycle pulse during the commit cycle
//   gen_count  out  CNT_W  committed generations since reset (wraps)
//
// Build option
//   LIFE_TORUS_EN : when defined, the grid edges wrap (torus topology).
//                   When undefined, cells outside the grid are dead.
//
// Revision : 1.0  initial release
// ============================================================================
module life_grid_engine #(
    parameter  int COLS  = 16,
    parameter  int ROWS  = 16,
    parameter  int CNT_W = 16,
    localparam int RW    = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    input  logic             run_enb,
    input  logic             load_enb,
    input  logic [RW-1:0]    load_row,
    input  logic [COLS-1:0]  load_data,
    input  logic [RW-1:0]    rd_row,
    output logic [COLS-1:0]  rd_data,
    output logic             busy,
    output logic             gen_done,
    output logic [CNT_W-1:0] gen_count
);

`ifdef LIFE_TORUS_EN
    localparam bit c_TORUS = 1'b1;
`else
    localparam bit c_TORUS = 1'b0;
`endif

    localparam logic [RW-1:0] c_LAST_ROW = RW'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_COMMIT  = 2'd2
    } state_t;

    state_t            r_state;
    logic [RW-1:0]     r_row;
    logic [COLS-1:0]   r_grid   [ROWS];
    logic [COLS-1:0]   r_shadow [ROWS];
    logic [COLS-1:0]   r_rd_data;
    logic              r_busy;
    logic              r_gen_done;
    logic [CNT_W-1:0]  r_gen_count;

    logic              w_rd_ok;
    logic              w_load_ok;

    // ------------------------------------------------------------------
    // Address range checks. When ROWS is a power of two every address is
    // in range, so the comparison is dropped altogether.
    // ------------------------------------------------------------------
    generate
        if (ROWS == (1 << RW)) begin : g_pow2_rows
            assign w_rd_ok   = 1'b1;
            assign w_load_ok = 1'b1;
        end else begin : g_npow2_rows
            localparam logic [RW:0] c_ROWS_EXT = (RW + 1)'(ROWS);
            assign w_rd_ok   = ({1'b0, rd_row}   < c_ROWS_EXT);
            assign w_load_ok = ({1'b0, load_row} < c_ROWS_EXT);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Neighbour rows for the row currently being computed. At the top and
    // bottom edges the missing row is either the opposite edge (torus) or
    // all dead.
    // ------------------------------------------------------------------
    logic [RW-1:0]   w_up_idx;
    logic [RW-1:0]   w_dn_idx;
    logic            w_up_valid;
    logic            w_dn_valid;
    logic [COLS-1:0] w_row_up;
    logic [COLS-1:0] w_row_mid;
    logic [COLS-1:0] w_row_dn;

    always_comb begin
        w_up_idx   = r_row - 1'b1;
        w_up_valid = 1'b1;
        if (r_row == '0) begin
            w_up_idx   = c_LAST_ROW;
            w_up_valid = c_TORUS;
        end

        w_dn_idx   = r_row + 1'b1;
        w_dn_valid = 1'b1;
        if (r_row == c_LAST_ROW) begin
            w_dn_idx   = '0;
            w_dn_valid = c_TORUS;
        end
    end

    assign w_row_up  = w_up_valid ? r_grid[w_up_idx] : '0;
    assign w_row_mid = r_grid[r_row];
    assign w_row_dn  = w_dn_valid ? r_grid[w_dn_idx] : '0;

    // Rows extended by one cell on each side: bit 0 is column -1 and bit
    // COLS+1 is column COLS, so column c sees bits c, c+1, c+2.
    logic [COLS+1:0] w_ext_up;
    logic [COLS+1:0] w_ext_mid;
    logic [COLS+1:0] w_ext_dn;

    assign w_ext_up  = {c_TORUS & w_row_up[0],  w_row_up,  c_TORUS & w_row_up[COLS-1]};
    assign w_ext_mid = {c_TORUS & w_row_mid[0], w_row_mid, c_TORUS & w_row_mid[COLS-1]};
    assign w_ext_dn  = {c_TORUS & w_row_dn[0],  w_row_dn,  c_TORUS & w_row_dn[COLS-1]};

    logic [COLS-1:0] w_next_row;

    generate
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [3:0] w_sum;

            // Eight neighbours, at most 8, so 4 bits never overflow.
            assign w_sum = {3'b000, w_ext_up[c]}  + {3'b000, w_ext_up[c+1]}
                         + {3'b000, w_ext_up[c+2]} + {3'b000, w_ext_mid[c]}
                         + {3'b000, w_ext_mid[c+2]} + {3'b000, w_ext_dn[c]}
                         + {3'b000, w_ext_dn[c+1]} + {3'b000, w_ext_dn[c+2]};

            // Birth on exactly 3; survival on 2 or 3.
            assign w_next_row[c] = (w_sum == 4'd3)
                                 | (w_ext_mid[c+1] & (w_sum == 4'd2));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Control, storage and registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_row       <= '0;
            r_busy      <= 1'b0;
            r_gen_done  <= 1'b0;
            r_gen_count <= '0;
            r_rd_data   <= '0;
            for (int i = 0; i < ROWS; i++) begin
                r_grid[i]   <= '0;
                r_shadow[i] <= '0;
            end
        end else begin
            r_gen_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    // A load in the same cycle as an accepted step lands in
                    // the grid before the first compute cycle reads it.
                    if (load_enb && w_load_ok) begin
                        r_grid[load_row] <= load_data;
                    end
                    if (step && run_enb) begin
                        r_state <= S_COMPUTE;
                        r_row   <= '0;
                        r_busy  <= 1'b1;
                    end
                end

                S_COMPUTE: begin
                    r_shadow[r_row] <= w_next_row;
                    if (r_row == c_LAST_ROW) begin
                        r_state    <= S_COMMIT;
                        r_gen_done <= 1'b1;
                    end else begin
                        r_row <= r_row + 1'b1;
                    end
                end

                S_COMMIT: begin
                    for (int i = 0; i < ROWS; i++) begin
                        r_grid[i] <= r_shadow[i];
                    end
                    r_gen_count <= r_gen_count + 1'b1;
                    r_row       <= '0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_row   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase

            r_rd_data <= w_rd_ok ? r_grid[rd_row] : '0;
        end
    end

    assign rd_data   = r_rd_data;
    assign busy      = r_busy;
    assign gen_done  = r_gen_done;
    assign gen_count = r_gen_count;

endmodule
`default_nettype wire
